// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset processor core: FETCH/DECODE/EXEC/MEM/WB controller
// driving request/ready instruction and data memory ports.
module multicycle_datapath #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic [2:0]        state_o,
    output logic              retire
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir, a, b, alu_out, mdr;
    logic [31:0]       regs [32];

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wr_addr;
    logic [31:0] imm_sext, alu_res, br_off, jt_wide, wb_data, rf_rs, rf_rt;
    logic        is_rtype, is_addi, is_lw, is_sw, is_beq, is_j, needs_mem_or_wb;
    logic        unused_shamt;

    assign opcode       = ir[31:26];
    assign rs           = ir[25:21];
    assign rt           = ir[20:16];
    assign rd           = ir[15:11];
    assign funct        = ir[5:0];
    assign imm_sext     = {{16{ir[15]}}, ir[15:0]};
    assign unused_shamt = ^ir[10:6];

    always_comb begin
        is_rtype = 1'b0;
        if (opcode == 6'h00) begin
            case (funct)
                6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: is_rtype = 1'b1;
                default:                           is_rtype = 1'b0;
            endcase
        end
    end

    assign is_addi         = (opcode == 6'h08);
    assign is_lw           = (opcode == 6'h23);
    assign is_sw           = (opcode == 6'h2B);
    assign is_beq          = (opcode == 6'h04);
    assign is_j            = (opcode == 6'h02);
    assign needs_mem_or_wb = is_rtype | is_addi | is_lw | is_sw;

    always_comb begin
        alu_res = a + imm_sext;
        if (is_rtype) begin
            case (funct)
                6'h22:   alu_res = a - b;
                6'h24:   alu_res = a & b;
                6'h25:   alu_res = a | b;
                6'h2A:   alu_res = {31'd0, $signed(a) < $signed(b)};
                default: alu_res = a + b;
            endcase
        end
    end

    // Jump keeps the PC's top nibble; masking the zero-extended PC lets the
    // same expression cover ADDR_W below 28, where only low target bits remain.
    always_comb begin
        jt_wide = '0;
        jt_wide[ADDR_W-1:0] = pc;
        jt_wide = (jt_wide & 32'hF000_0000) | {4'h0, ir[25:0], 2'b00};
        br_off  = imm_sext << 2;
    end

    assign rf_rs   = (rs == 5'd0) ? '0 : regs[rs];
    assign rf_rt   = (rt == 5'd0) ? '0 : regs[rt];
    assign wr_addr = is_rtype ? rd : rt;
    assign wb_data = is_lw ? mdr : alu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (imem_ready) state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC: begin
                if (is_rtype || is_addi)  state_next = WB;
                else if (is_lw || is_sw)  state_next = MEM;
                else                      state_next = FETCH;
            end
            MEM:     if (dmem_ready) state_next = is_sw ? FETCH : WB;
            WB:      state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // imem_req is qualified by rst_n so it stays low while reset is held,
    // even though the state register already sits in FETCH.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        case (state)
            FETCH: imem_req = rst_n;
            EXEC:  retire   = !needs_mem_or_wb;
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                retire   = is_sw && dmem_ready;
            end
            WB:      retire = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_PC[ADDR_W-1:0];
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            mdr     <= '0;
            for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        ir <= imem_rdata;
                        pc <= pc + ADDR_W'(4);
                    end
                end
                DECODE: begin
                    a <= rf_rs;
                    b <= rf_rt;
                end
                EXEC: begin
                    alu_out <= alu_res;
                    if (is_beq && (a == b)) pc <= pc + br_off[ADDR_W-1:0];
                    if (is_j)               pc <= jt_wide[ADDR_W-1:0];
                end
                MEM:     if (dmem_ready && !is_sw) mdr <= dmem_rdata;
                WB:      if (wr_addr != 5'd0) regs[wr_addr] <= wb_data;
                default: ;
            endcase
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = alu_out[ADDR_W-1:0];
    assign dmem_wdata = b;
    assign pc_o       = pc;
    assign state_o    = state;

endmodule

// File: doc/multicycle_datapath.md
MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

Interface
REQ-001 Parameter ADDR_W, default 32, width of PC and memory addresses; SHALL be in the range 8..32.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; SHALL be word-aligned.
REQ-003 Data and instruction width SHALL be fixed at 32; register file SHALL be 32 x 32, with register 0 reading as zero.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  ADDR_W  fetch address (current PC).
REQ-008 imem_rdata  input  32  instruction word.
REQ-009 imem_ready  input  1  fetch complete; rdata valid this cycle.
REQ-010 dmem_req  output  1  data access request.
REQ-011 dmem_we  output  1  1 = store, 0 = load; valid while dmem_req = 1.
REQ-012 dmem_addr  output  ADDR_W  data address (ALU result, truncated to ADDR_W).
REQ-013 dmem_wdata  output  32  store data (rt value).
REQ-014 dmem_rdata  input  32  load data.
REQ-015 dmem_ready  input  1  data access complete; rdata valid this cycle.
REQ-016 pc_o  output  ADDR_W  architectural PC.
REQ-017 state_o  output  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
REQ-018 retire  output  1  one-cycle pulse on the last cycle of each instruction.

Function
REQ-019 Supported instructions SHALL be R-type add/sub/and/or/slt (funct 20/22/24/25/2A hex), plus lw (23), sw (2B), beq (04), addi (08) and j (02).
REQ-020 FETCH: imem_req = 1 and imem_addr = PC; the FSM SHALL hold while imem_ready = 0.
  - On imem_ready: latch IR, set PC <= PC + 4, go to DECODE.
REQ-021 DECODE: latch A = reg[rs] and B = reg[rt]; go to EXEC.
REQ-022 EXEC, R-type / addi: latch ALUOut; go to WB.
  - addi SHALL use the sign-extended imm16.
  - slt SHALL be a signed compare and yield 1 or 0.
  - Add and sub SHALL wrap modulo 2^32 with no overflow trap.
REQ-023 EXEC, lw / sw: ALUOut = A + sext(imm16); go to MEM.
REQ-024 EXEC, beq: if A == B then PC <= PC + (sext(imm16) << 2), truncated to ADDR_W; retire; go to FETCH.
REQ-025 EXEC, j: PC <= {PC[ADDR_W-1:28], target26, 2'b00}; go to FETCH.
  - When ADDR_W <= 28, the low ADDR_W bits of {target26, 2'b00} SHALL be used.
  - Retire.
REQ-026 Unsupported opcode or funct SHALL execute as a NOP: no register or memory write; retire in EXEC; go to FETCH.
REQ-027 MEM: dmem_req = 1 and the FSM SHALL hold until dmem_ready.
  - sw (dmem_we = 1): retire; go to FETCH.
  - lw (dmem_we = 0): latch MDR = dmem_rdata; go to WB.
REQ-028 WB: write ALUOut (R-type/addi) or MDR (lw) to rd (R-type) or rt (addi/lw); retire; go to FETCH.
  - Writes to register 0 SHALL be discarded.
REQ-029 The DECODE read of a register written in the immediately preceding WB SHALL return the new value (the write completes one cycle earlier).
REQ-030 imem_req and dmem_req SHALL never be asserted in the same cycle.
  - Each SHALL stay asserted continuously until its ready is sampled high.
  - Ready inputs outside their request state SHALL be ignored.
REQ-031 Zero-wait-state cycle counts SHALL be:
  - R-type and addi: 4
  - lw: 5
  - sw: 4
  - beq and j: 3
  - NOP: 3
  - Each wait cycle adds one.

Reset
REQ-032 While rst_n = 0:
  - PC = RESET_PC, state = FETCH.
  - IR, A, B, ALUOut and MDR = 0; all 32 registers = 0.
  - imem_req = dmem_req = dmem_we = retire = 0.
REQ-033 Reset asserted mid-instruction (including during a pending memory wait) SHALL abort it with no register write; a pending request SHALL drop in the same cycle.
REQ-034 On the first clock after rst_n rises, imem_req SHALL be 1 with imem_addr = RESET_PC.

Verification
REQ-035 Reset then addi $1,$0,5 (0x20010005) with zero-wait imem -> reg1 = 5, pc_o = 4, retire on cycle 4.
REQ-036 add $3,$1,$2 with reg1 = 0xFFFFFFFF and reg2 = 2 -> reg3 = 1; slt $4,$1,$2 -> reg4 = 1.
REQ-037 sw $1,8($0), then lw $5,8($0) against a 1-entry memory model with dmem_ready delayed 3 cycles:
  - dmem_req is held for 4 cycles.
  - reg5 = stored value.
  - lw takes 8 cycles.
REQ-038 beq $0,$0,-1 at PC 0x10 -> PC returns to 0x10, 3 cycles; j 0x40 -> pc_o = 0x100.
REQ-039 Drop rst_n during MEM of an lw -> dmem_req = 0 immediately, target register unchanged, refetch from RESET_PC.
REQ-040 addi $0,$0,7 followed by add $6,$0,$0 -> reg6 = 0; opcode 0x3F -> NOP, retire in 3 cycles, no writes.
